work_loader: RTL and testbench
==============================

Name: work_loader

Overview:
Upstream feeder for the mining core. Takes a byte stream from the host UART receiver (valid/ready), frames it as sync byte + 80-byte block header + 1 XOR checksum byte, and verifies the checksum. Presents each verified header to the miner core over a valid/ready handshake. Malformed or stalled frames are dropped and counted; the core never sees a partial header.

Parameters:
HEADER_BYTES, 80, header payload length in bytes
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 100000, max idle clocks between bytes inside a frame before abort
CNT_W, 17, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock; the only clock
reset  in  1  synchronous, active-high reset
in_data  in  8  received byte from UART RX
in_valid  in  1  in_data valid
in_ready  out  1  loader accepts byte; a byte transfers when in_valid && in_ready
work_header  out  8*HEADER_BYTES  verified header; header byte i at bits [8i+7:8i]; byte 0 is the first byte received after sync
work_valid  out  1  work_header holds a verified, unconsumed header
work_ready  in  1  miner core accepts the header
err_cksum  out  1  one-cycle pulse on checksum mismatch
err_timeout  out  1  one-cycle pulse on inter-byte timeout abort
err_count  out  8  saturating count of all errors (checksum + timeout)
busy  out  1  high in LOAD or CKSUM

Behaviour:
- Reset (synchronous, active-high, sampled on rising clk) -> state IDLE. in_ready=0 during the reset cycle and 1 from the first cycle after. work_valid=0, work_header=0, err pulses=0, err_count=0, busy=0. Reset asserted mid-frame or in HOLD discards everything. An offered header is withdrawn even if work_ready is high in that cycle.
- Registers: load buffer (8*HEADER_BYTES), output register work_header (same width), byte index (7 bits), running XOR (8 bits), timeout counter (CNT_W bits).
- IDLE: in_ready=1. An accepted byte equal to SYNC_BYTE clears the index, XOR and timer, then goes to LOAD. Other bytes are accepted and silently discarded.
- LOAD: in_ready=1. Each accepted byte is written to buffer[index], XOR ^= byte, index++. SYNC_BYTE values inside the payload are plain data and cause no resync. On acceptance of byte HEADER_BYTES-1, go to CKSUM.
- CKSUM: in_ready=1. On the accepted byte:
  - byte == XOR: copy buffer to work_header and go to HOLD. work_valid is 1 in the next cycle, so latency is 1 cycle from checksum acceptance.
  - mismatch: err_cksum pulses in the next cycle, err_count++, go to IDLE. work_header is left unchanged.
- HOLD: in_ready=0, so the UART side is back-pressured. work_valid=1 and work_header is stable until handshake. On work_valid && work_ready, work_valid=0 next cycle, state IDLE, in_ready=1 next cycle. Minimum HOLD duration is 1 cycle (work_ready already high).
- Timeout: in LOAD/CKSUM, the timer increments every cycle without an accepted byte and clears on each accepted byte. When the timer reaches TIMEOUT_CYCLES, err_timeout pulses, err_count++, state IDLE. A byte accepted in the same cycle as the timeout is dropped; timeout wins.
- err_count saturates at 255 and never wraps. Both pulses can never occur in the same cycle.
- busy = (state==LOAD || state==CKSUM).

Decomposition:
- Shared package/header holds: state encodings (IDLE, LOAD, CKSUM, HOLD), SYNC_BYTE default, HEADER_BYTES default, header byte-lane macro.
- No sub-module is required. The inter-byte timeout counter may be split out as frame_timer (count enable, clear, expired flag) for reuse by the result transmitter.

Test Plan:
- Good frame: A5, bytes 00..4F, checksum 0x00 (XOR of 00..4F) -> work_valid=1 one cycle after the checksum byte; work_header[7:0]=00, [639:632]=4F; in_ready=0 until work_ready.
- Bad checksum: same frame with checksum 0x01 -> err_cksum pulse, err_count=1, work_valid stays 0, work_header unchanged (0 after reset).
- Timeout: A5 + 10 bytes, then in_valid=0 for 100000 cycles -> err_timeout pulse, state IDLE, err_count=1; a following good frame is accepted normally.
- Back-pressure: work_ready held 0 for 50 cycles after a good frame, in_valid=1 continuously -> work_valid and work_header stable, no bytes accepted. work_ready=1 -> work_valid=0 and in_ready=1 next cycle.
- Payload containing 0xA5 at bytes 3 and 40 with correct checksum -> frame accepted intact, no resync.
- Reset asserted at byte 30 of a frame, then a good frame -> all outputs zero after reset; second frame delivered correctly. 300 bad frames -> err_count saturates at 255.

Source files
------------

// File: rtl/work_loader_pkg.sv
// work_loader_pkg: shared definitions for the work loader slice.
//   - loader FSM state encoding
//   - default frame geometry (header length, sync marker)
//   - helper that locates a header byte lane inside the flat header bus
package work_loader_pkg;

    localparam int unsigned HEADER_BYTES_DEF = 80;
    localparam logic [7:0]  SYNC_BYTE_DEF    = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CKSUM = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // LSB position of header byte i in the flat header bus; use as [lsb +: 8].
    function automatic int unsigned hdr_lane_lsb(input int unsigned i);
        return i * 8;
    endfunction

endpackage

// File: rtl/work_loader_if.sv
// work_loader_if: byte-stream input and header-output handshakes of the loader.
//   in_data/in_valid/in_ready          : UART RX byte stream (valid/ready)
//   work_header/work_valid/work_ready  : verified header to the miner core
// Modports:
//   slave  : the loader side (accepts bytes, offers headers)
//   master : the environment side (host byte source + miner core)
import work_loader_pkg::*;

interface work_loader_if #(
    parameter int unsigned HEADER_BYTES = HEADER_BYTES_DEF
);
    logic [7:0]                in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic [8*HEADER_BYTES-1:0] work_header;
    logic                      work_valid;
    logic                      work_ready;

    modport slave (
        input  in_data, in_valid, work_ready,
        output in_ready, work_header, work_valid
    );

    modport master (
        output in_data, in_valid, work_ready,
        input  in_ready, work_header, work_valid
    );
endinterface

// File: rtl/work_loader_frame_timer.sv
// work_loader_frame_timer: inter-byte idle timer.
//   clk, reset : clock and synchronous active-high reset
//   en         : count one idle cycle
//   clr        : restart from zero (has priority over en)
//   expired    : count has reached LIMIT; holds there until cleared
module work_loader_frame_timer #(
    parameter int unsigned LIMIT = 100000,
    parameter int unsigned CNT_W = 17
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic expired
);
    logic [CNT_W-1:0] cnt_q;

    assign expired = (cnt_q == CNT_W'(LIMIT));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_q <= '0;
        end else if (en && !expired) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: rtl/work_loader.sv
// work_loader: frames the host byte stream as SYNC + header + XOR checksum,
// verifies it, and offers each good header to the miner core.
//   clk, reset  : clock, synchronous active-high reset
//   bus         : work_loader_if.slave (byte input + header output handshakes)
//   err_cksum   : one-cycle pulse after a checksum mismatch
//   err_timeout : one-cycle pulse after an inter-byte timeout abort
//   err_count   : saturating count of both error kinds
//   busy        : frame in progress (LOAD or CKSUM)
import work_loader_pkg::*;

module work_loader #(
    parameter int unsigned HEADER_BYTES   = HEADER_BYTES_DEF,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned CNT_W          = 17
) (
    input  logic        clk,
    input  logic        reset,
    work_loader_if.slave bus,
    output logic        err_cksum,
    output logic        err_timeout,
    output logic [7:0]  err_count,
    output logic        busy
);
    localparam int unsigned IDX_W = 7;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HEADER_BYTES - 1);

    state_t state_q, state_d;

    logic [HEADER_BYTES-1:0][7:0] buf_q;
    logic [HEADER_BYTES-1:0][7:0] hdr_q;
    logic [IDX_W-1:0]             idx_q;
    logic [7:0]                   xor_q;

    logic rdy;
    logic in_fire;
    logic expired;
    logic sync_seen;
    logic load_wr;
    logic cksum_ok;
    logic cksum_bad;
    logic timeout;

    // Ready depends only on registered state, so the acceptance strobe
    // used by the FSM has no combinational loop back into itself.
    assign rdy     = !reset && (state_q != ST_HOLD);
    assign in_fire = bus.in_valid && rdy;

    assign bus.in_ready    = rdy;
    assign bus.work_valid  = (state_q == ST_HOLD);
    assign bus.work_header = hdr_q;
    assign busy            = (state_q == ST_LOAD) || (state_q == ST_CKSUM);

    // Timer runs only inside a frame; any accepted byte restarts it.
    work_loader_frame_timer #(
        .LIMIT (TIMEOUT_CYCLES),
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .en      (1'b1),
        .clr     (!busy || in_fire),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sync_seen = 1'b0;
        load_wr   = 1'b0;
        cksum_ok  = 1'b0;
        cksum_bad = 1'b0;
        timeout   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_fire && bus.in_data == SYNC_BYTE) begin
                    sync_seen = 1'b1;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Timeout wins over a byte arriving in the same cycle.
                if (expired) begin
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                end else if (in_fire) begin
                    load_wr = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_CKSUM;
                    end
                end
            end
            ST_CKSUM: begin
                if (expired) begin
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                end else if (in_fire) begin
                    if (bus.in_data == xor_q) begin
                        cksum_ok = 1'b1;
                        state_d  = ST_HOLD;
                    end else begin
                        cksum_bad = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.work_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q       <= '0;
            hdr_q       <= '0;
            idx_q       <= '0;
            xor_q       <= '0;
            err_cksum   <= 1'b0;
            err_timeout <= 1'b0;
            err_count   <= '0;
        end else begin
            err_cksum   <= cksum_bad;
            err_timeout <= timeout;
            if ((cksum_bad || timeout) && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
            if (sync_seen) begin
                idx_q <= '0;
                xor_q <= '0;
            end
            if (load_wr) begin
                buf_q[idx_q] <= bus.in_data;
                xor_q        <= xor_q ^ bus.in_data;
                idx_q        <= idx_q + IDX_W'(1);
            end
            if (cksum_ok) begin
                hdr_q <= buf_q;
            end
        end
    end
endmodule

// File: tb/tb_work_loader.sv
// tb_work_loader: directed self-checking bench for work_loader.
import work_loader_pkg::*;

module tb_work_loader;
    localparam int unsigned HB = 80;
    localparam int unsigned TO = 1000;

    logic       clk = 1'b0;
    logic       reset;
    logic       err_cksum, err_timeout, busy;
    logic [7:0] err_count;

    int tests = 0;
    int fails = 0;

    logic [8*HB-1:0] hdr_good, hdr_a5, hdr_r;

    work_loader_if #(.HEADER_BYTES(HB)) bus ();

    work_loader #(
        .HEADER_BYTES   (HB),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (17)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .err_cksum   (err_cksum),
        .err_timeout (err_timeout),
        .err_count   (err_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chkh(input string tag, input logic [8*HB-1:0] obs, input logic [8*HB-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the following posedge takes the byte.
    task automatic send(input logic [7:0] b);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [8*HB-1:0] hdr, input logic [7:0] ck);
        send(8'hA5);
        for (int unsigned i = 0; i < HB; i++) send(hdr[hdr_lane_lsb(i) +: 8]);
        send(ck);
    endtask

    initial begin
        int waited;
        for (int unsigned i = 0; i < HB; i++) hdr_good[hdr_lane_lsb(i) +: 8] = 8'(i);
        hdr_a5 = hdr_good;
        hdr_a5[hdr_lane_lsb(3) +: 8]  = 8'hA5;
        hdr_a5[hdr_lane_lsb(40) +: 8] = 8'hA5;
        hdr_r = hdr_good;
        hdr_r[7:0] = 8'h11;

        reset          = 1'b1;
        bus.in_data    = 8'h00;
        bus.in_valid   = 1'b0;
        bus.work_ready = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk1("rst_in_ready_during", bus.in_ready, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk1("rst_in_ready_after", bus.in_ready, 1'b1);
        chk1("rst_work_valid", bus.work_valid, 1'b0);
        chkh("rst_header", bus.work_header, '0);
        chk8("rst_err_count", err_count, 8'h00);
        chk1("rst_busy", busy, 1'b0);

        // Good frame, then 50 cycles of back-pressure with in_valid held high
        send_frame(hdr_good, 8'h00);
        chk1("good_work_valid", bus.work_valid, 1'b1);
        chk1("good_in_ready", bus.in_ready, 1'b0);
        chk8("good_byte0", bus.work_header[7:0], 8'h00);
        chk8("good_byte79", bus.work_header[639:632], 8'h4F);
        chkh("good_header", bus.work_header, hdr_good);
        bus.in_data = 8'hA5;
        for (int i = 0; i < 50; i++) @(negedge clk);
        chk1("bp_work_valid", bus.work_valid, 1'b1);
        chk1("bp_in_ready", bus.in_ready, 1'b0);
        chk1("bp_busy", busy, 1'b0);
        chkh("bp_header", bus.work_header, hdr_good);
        bus.work_ready = 1'b1;
        @(negedge clk);
        chk1("hs_work_valid", bus.work_valid, 1'b0);
        chk1("hs_in_ready", bus.in_ready, 1'b1);
        bus.in_valid   = 1'b0;
        bus.work_ready = 1'b0;
        @(negedge clk);
        chk1("hs_no_stray_load", busy, 1'b0);

        // Bad checksum
        send_frame(hdr_good, 8'h01);
        bus.in_valid = 1'b0;
        chk1("bad_err_cksum", err_cksum, 1'b1);
        chk1("bad_err_timeout", err_timeout, 1'b0);
        chk8("bad_err_count", err_count, 8'd1);
        chk1("bad_work_valid", bus.work_valid, 1'b0);
        chkh("bad_header_kept", bus.work_header, hdr_good);
        @(negedge clk);
        chk1("bad_pulse_end", err_cksum, 1'b0);

        // Timeout: sync + 10 bytes, then silence
        send(8'hA5);
        for (int i = 0; i < 10; i++) send(8'(i));
        bus.in_valid = 1'b0;
        chk1("to_busy", busy, 1'b1);
        waited = 0;
        for (int i = 1; i <= TO + 100 && waited == 0; i++) begin
            @(negedge clk);
            if (err_timeout) waited = i;
        end
        chk32("to_latency", waited, TO + 1);
        chk1("to_err_cksum", err_cksum, 1'b0);
        chk1("to_busy_after", busy, 1'b0);
        chk8("to_err_count", err_count, 8'd2);
        @(negedge clk);
        chk1("to_pulse_end", err_timeout, 1'b0);
        send_frame(hdr_good, 8'h00);
        bus.in_valid = 1'b0;
        chk1("to_next_valid", bus.work_valid, 1'b1);
        chkh("to_next_header", bus.work_header, hdr_good);
        bus.work_ready = 1'b1;
        @(negedge clk);
        chk1("to_next_hs", bus.work_valid, 1'b0);

        // 0xA5 inside payload, work_ready already high (single-cycle HOLD)
        send_frame(hdr_a5, 8'h2B);
        chk1("a5_work_valid", bus.work_valid, 1'b1);
        chkh("a5_header", bus.work_header, hdr_a5);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk1("a5_hold_min", bus.work_valid, 1'b0);
        chk1("a5_in_ready", bus.in_ready, 1'b1);
        chk8("a5_err_count", err_count, 8'd2);
        bus.work_ready = 1'b0;

        // Reset at byte 30 of a frame, then a good frame
        send(8'hA5);
        for (int i = 0; i < 30; i++) send(8'(i));
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk1("mid_rst_in_ready", bus.in_ready, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_work_valid", bus.work_valid, 1'b0);
        chkh("mid_rst_header", bus.work_header, '0);
        chk8("mid_rst_err_count", err_count, 8'd0);
        send_frame(hdr_r, 8'h11);
        bus.in_valid = 1'b0;
        chk1("mid_rst_next_valid", bus.work_valid, 1'b1);
        chkh("mid_rst_next_header", bus.work_header, hdr_r);
        bus.work_ready = 1'b1;
        @(negedge clk);
        bus.work_ready = 1'b0;

        // 300 bad frames: counter saturates at 255
        for (int i = 1; i <= 300; i++) begin
            send_frame(hdr_good, 8'h01);
            if (i == 254) chk8("sat_254", err_count, 8'd254);
            if (i == 255) chk8("sat_255", err_count, 8'd255);
        end
        bus.in_valid = 1'b0;
        chk1("sat_pulse", err_cksum, 1'b1);
        chk8("sat_300", err_count, 8'd255);
        chk1("sat_work_valid", bus.work_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
